// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver weight path.
package conv_pkg;

  localparam int unsigned WEIGHT_W    = 32;
  localparam int unsigned KERNEL_TAPS = 9;

  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } wstate_e;

endpackage

// File: rtl/weight_bank.sv
// N-entry weight register array.
// Ports: clk, reset (async, active-high); wr_en/wr_idx/wr_data single-entry write;
//        load_en/load_data parallel load of all entries (wins over wr_en);
//        rd_data flattened contents, entry j at [j*BIT_WIDTH +: BIT_WIDTH].
module weight_bank
  import conv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = WEIGHT_W,
  parameter int unsigned N         = KERNEL_TAPS,
  parameter int unsigned IDX_W     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [BIT_WIDTH-1:0]   wr_data,
  input  logic                   load_en,
  input  logic [N*BIT_WIDTH-1:0] load_data,
  output logic [N*BIT_WIDTH-1:0] rd_data
);

  logic [BIT_WIDTH-1:0] mem_q [N];
  logic [BIT_WIDTH-1:0] mem_d [N];

  // Next-entry selection: parallel load, else indexed write, else hold.
  always_comb begin
    for (int j = 0; j < int'(N); j++) begin
      mem_d[j] = mem_q[j];
      if (load_en) begin
        mem_d[j] = load_data[j*BIT_WIDTH +: BIT_WIDTH];
      end else if (wr_en && (wr_idx == IDX_W'(j))) begin
        mem_d[j] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < int'(N); j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < int'(N); j++) begin
        mem_q[j] <= mem_d[j];
      end
    end
  end

  // Flattened read straight from the flops.
  for (genvar g = 0; g < int'(N); g++) begin : g_rd
    assign rd_data[g*BIT_WIDTH +: BIT_WIDTH] = mem_q[g];
  end

endmodule

// File: rtl/weight_dbuf_register.sv
// Double-buffered kernel weight register. Words stream into a shadow bank
// under valid/ready; a swap at a frame boundary copies the full shadow set
// into the active bank that drives the convolver.
// Ports: clk, reset (async, active-high); weight_valid/weight_in/weight_ready
//        serial load, tap 0 first; clear aborts a shadow load; swap_req
//        promotes a full shadow; weight_out active bank (flattened);
//        active_valid, shadow_full status; swap_err pulse on a premature swap.
module weight_dbuf_register
  import conv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = WEIGHT_W,
  parameter int unsigned N         = KERNEL_TAPS,
  parameter int unsigned IDX_W     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   weight_valid,
  input  logic [BIT_WIDTH-1:0]   weight_in,
  output logic                   weight_ready,
  input  logic                   clear,
  input  logic                   swap_req,
  output logic [N*BIT_WIDTH-1:0] weight_out,
  output logic                   active_valid,
  output logic                   shadow_full,
  output logic                   swap_err
);

  wstate_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             active_valid_q, active_valid_d;
  logic             shadow_full_q, shadow_full_d;
  logic             swap_err_q, swap_err_d;
  logic             weight_ready_q, weight_ready_d;

  logic             accept_c;
  logic             shadow_wr_c;
  logic             active_load_c;
  logic [N*BIT_WIDTH-1:0] shadow_data;

  assign accept_c = weight_valid & weight_ready_q;

  // Next state and bank controls; clear dominates words and swaps.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    active_valid_d = active_valid_q;
    swap_err_d     = 1'b0;
    shadow_wr_c    = 1'b0;
    active_load_c  = 1'b0;

    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            shadow_wr_c = 1'b1;
            idx_d       = IDX_W'(1);
            state_d     = LOAD;
          end
          if (swap_req) swap_err_d = 1'b1;
        end
        LOAD: begin
          if (accept_c) begin
            shadow_wr_c = 1'b1;
            if (idx_q == IDX_W'(N - 1)) begin
              idx_d   = '0;
              state_d = FULL;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          // A swap racing the final word is refused; a fresh request is needed.
          if (swap_req) swap_err_d = 1'b1;
        end
        FULL: begin
          if (swap_req) begin
            active_load_c  = 1'b1;
            active_valid_d = 1'b1;
            state_d        = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    weight_ready_d = (state_d != FULL);
    shadow_full_d  = (state_d == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      active_valid_q <= 1'b0;
      shadow_full_q  <= 1'b0;
      swap_err_q     <= 1'b0;
      weight_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      active_valid_q <= active_valid_d;
      shadow_full_q  <= shadow_full_d;
      swap_err_q     <= swap_err_d;
      weight_ready_q <= weight_ready_d;
    end
  end

  assign weight_ready = weight_ready_q;
  assign active_valid = active_valid_q;
  assign shadow_full  = shadow_full_q;
  assign swap_err     = swap_err_q;

  // Shadow bank: indexed writes from the serial stream.
  weight_bank #(
    .BIT_WIDTH (BIT_WIDTH),
    .N         (N),
    .IDX_W     (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (shadow_wr_c),
    .wr_idx    (idx_q),
    .wr_data   (weight_in),
    .load_en   (1'b0),
    .load_data ('0),
    .rd_data   (shadow_data)
  );

  // Active bank: one-cycle parallel copy of the shadow on swap.
  weight_bank #(
    .BIT_WIDTH (BIT_WIDTH),
    .N         (N),
    .IDX_W     (IDX_W)
  ) u_active (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .load_en   (active_load_c),
    .load_data (shadow_data),
    .rd_data   (weight_out)
  );

endmodule

// File: tb/tb_weight_dbuf_register.sv
// Directed bench for weight_dbuf_register.
module tb_weight_dbuf_register;

  localparam int unsigned BW = 32;
  localparam int unsigned N  = 9;
  localparam int unsigned VW = N * BW;

  logic          clk;
  logic          reset;
  logic          weight_valid;
  logic [BW-1:0] weight_in;
  logic          weight_ready;
  logic          clear;
  logic          swap_req;
  logic [VW-1:0] weight_out;
  logic          active_valid;
  logic          shadow_full;
  logic          swap_err;

  int n_checks = 0;
  int n_fail   = 0;

  weight_dbuf_register #(.BIT_WIDTH(BW), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .weight_valid (weight_valid),
    .weight_in    (weight_in),
    .weight_ready (weight_ready),
    .clear        (clear),
    .swap_req     (swap_req),
    .weight_out   (weight_out),
    .active_valid (active_valid),
    .shadow_full  (shadow_full),
    .swap_err     (swap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Kernel vector with tap j = first + j*step.
  function automatic logic [VW-1:0] kern(input int unsigned first, input int unsigned step);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < int'(N); j++) v[j*BW +: BW] = BW'(first + j * step);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n words (first + i*step); optional idle cycle after each word.
  task automatic load(input int unsigned first, input int unsigned step, input int n,
                      input bit gap, input logic [VW-1:0] hold);
    for (int i = 0; i < n; i++) begin
      weight_valid = 1'b1;
      weight_in    = BW'(first + i * step);
      check("ready_during_load", VW'(weight_ready), VW'(1'b1));
      tick();
      if (gap) begin
        weight_valid = 1'b0;
        check("out_stable_during_load", weight_out, hold);
        tick();
      end
    end
    weight_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] cur;
    reset = 1'b1; weight_valid = 1'b0; weight_in = '0; clear = 1'b0; swap_req = 1'b0;
    #2;
    check("rst_weight_out", weight_out, '0);
    check("rst_active_valid", VW'(active_valid), '0);
    check("rst_ready", VW'(weight_ready), '0);
    check("rst_shadow_full", VW'(shadow_full), '0);
    check("rst_swap_err", VW'(swap_err), '0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("ready_after_rst", VW'(weight_ready), VW'(1'b1));

    // Back-to-back load of 1..9, then swap.
    load(1, 1, 9, 1'b0, '0);
    check("t1_shadow_full", VW'(shadow_full), VW'(1'b1));
    check("t1_ready_full", VW'(weight_ready), '0);
    check("t1_out_before_swap", weight_out, '0);
    do_swap();
    check("t1_out", weight_out, kern(1, 1));
    check("t1_active_valid", VW'(active_valid), VW'(1'b1));
    check("t1_shadow_empty", VW'(shadow_full), '0);
    check("t1_ready_idle", VW'(weight_ready), VW'(1'b1));

    // Toggled-valid load while the active set stays visible.
    load(32'h10, 1, 9, 1'b1, kern(1, 1));
    check("t2_shadow_full", VW'(shadow_full), VW'(1'b1));
    do_swap();
    check("t2_out", weight_out, kern(32'h10, 1));

    // Premature swap after 4 words.
    cur = kern(32'h10, 1);
    load(32'h30, 1, 4, 1'b0, '0);
    do_swap();
    check("t3_swap_err", VW'(swap_err), VW'(1'b1));
    check("t3_out_unchanged", weight_out, cur);
    check("t3_not_full", VW'(shadow_full), '0);
    check("t3_still_ready", VW'(weight_ready), VW'(1'b1));
    tick();
    check("t3_err_one_cycle", VW'(swap_err), '0);
    load(32'h34, 1, 5, 1'b0, '0);
    check("t3_full", VW'(shadow_full), VW'(1'b1));
    do_swap();
    check("t3_out", weight_out, kern(32'h30, 1));

    // Clear after 6 words, then a fresh 0xAA load.
    load(1, 1, 6, 1'b0, '0);
    clear = 1'b1;
    weight_valid = 1'b1; weight_in = 32'hDEAD;
    tick();
    clear = 1'b0; weight_valid = 1'b0;
    check("t4_clear_not_full", VW'(shadow_full), '0);
    check("t4_out_kept", weight_out, kern(32'h30, 1));
    load(32'hAA, 0, 9, 1'b0, '0);
    check("t4_full", VW'(shadow_full), VW'(1'b1));
    do_swap();
    check("t4_out_aa", weight_out, kern(32'hAA, 0));

    // Clear beats swap in FULL.
    load(32'h50, 1, 9, 1'b0, '0);
    clear = 1'b1; swap_req = 1'b1;
    tick();
    clear = 1'b0; swap_req = 1'b0;
    check("t4b_no_swap", weight_out, kern(32'hAA, 0));
    check("t4b_no_err", VW'(swap_err), '0);
    check("t4b_idle", VW'(shadow_full), '0);

    // Final word coinciding with swap_req.
    load(32'h60, 1, 8, 1'b0, '0);
    weight_valid = 1'b1; weight_in = 32'h68; swap_req = 1'b1;
    tick();
    weight_valid = 1'b0; swap_req = 1'b0;
    check("t5_full", VW'(shadow_full), VW'(1'b1));
    check("t5_err", VW'(swap_err), VW'(1'b1));
    check("t5_out_unchanged", weight_out, kern(32'hAA, 0));
    do_swap();
    check("t5_out", weight_out, kern(32'h60, 1));
    check("t5_err_clear", VW'(swap_err), '0);

    // Words offered while FULL are refused.
    load(32'h70, 1, 9, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      weight_valid = 1'b1; weight_in = 32'hFF;
      check("t6_ready_low", VW'(weight_ready), '0);
      tick();
    end
    weight_valid = 1'b0;
    do_swap();
    check("t6_out", weight_out, kern(32'h70, 1));

    // Asynchronous reset mid-load.
    load(32'h80, 1, 3, 1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    check("t7_out_zero", weight_out, '0);
    check("t7_active_invalid", VW'(active_valid), '0);
    check("t7_ready_low", VW'(weight_ready), '0);
    tick();
    reset = 1'b0;
    tick();
    check("t7_not_full", VW'(shadow_full), '0);
    check("t7_ready", VW'(weight_ready), VW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_dbuf_register.md
Name: weight_dbuf_register

Overview:
- Double-buffered, clocked successor to the combinational weight latch; holds one N-tap kernel for the convolver.
- Weights stream into a shadow bank one word per valid/ready handshake while the convolver keeps reading the stable active bank.
- A swap request, issued at a frame boundary, copies the completed shadow set into the active bank in one cycle.

Parameters:
- BIT_WIDTH, 32, width of one weight word.
- N, 9, taps per kernel (3x3); must be >= 2.
- IDX_W, $clog2(N), width of the load index counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- weight_valid  input  1  weight_in holds a valid word this cycle.
- weight_in  input  BIT_WIDTH  serial weight word, tap 0 first.
- weight_ready  output  1  block accepts a word this cycle.
- clear  input  1  synchronous abort of an in-progress shadow load.
- swap_req  input  1  one-cycle pulse: promote the shadow bank to active.
- weight_out  output  N*BIT_WIDTH  active bank, flattened; tap j at [j*BIT_WIDTH +: BIT_WIDTH].
- active_valid  output  1  active bank holds a complete set.
- shadow_full  output  1  shadow bank holds N words, waiting for a swap.
- swap_err  output  1  one-cycle pulse: swap_req arrived while shadow not full.

Behaviour:
- Reset (async): both banks 0, idx 0, state IDLE, weight_out 0, active_valid 0, shadow_full 0, swap_err 0, weight_ready 0 during reset.
- FSM states: IDLE, LOAD, FULL. weight_ready = 1 in IDLE and LOAD, 0 in FULL.
- Accepted word = weight_valid & weight_ready at the clock edge.
- IDLE: an accepted word writes shadow[0], sets idx to 1, moves to LOAD.
- LOAD: an accepted word writes shadow[idx], increments idx. When idx == N-1 is written, idx wraps to 0 and state goes to FULL. There is no back-pressure gap between words; one word per cycle is sustained.
- FULL: shadow_full = 1; further weight_valid is ignored because ready = 0.
- Swap: swap_req in FULL moves the active bank to the shadow contents on the next edge. In the same edge active_valid goes to 1, state goes to IDLE and shadow_full goes to 0. The shadow contents are retained but are not reused.
- weight_out is registered; it changes only on a swap or a reset. Latency from swap_req to the new weight_out is 1 cycle.
- swap_req in IDLE or LOAD: no swap, no state change; swap_err pulses high for 1 cycle.
- Simultaneous swap_req and the final (Nth) accepted word: the word completes the shadow and state goes to FULL; the swap is not taken. swap_err pulses, and a fresh swap_req is required.
- clear: in LOAD or FULL, idx goes to 0 and state to IDLE; the active bank is untouched. clear has priority over a word accepted in the same cycle, and that word is dropped. clear and swap_req together in FULL: clear wins, no swap, no swap_err.
- Reset mid-load: the partial shadow set is discarded, and active_valid returns to 0.
- All values are unsigned bit copies; no arithmetic is performed on the weights.

Decomposition:
- Shared package conv_pkg holds:
  - the typedef weight_t = logic [BIT_WIDTH-1:0];
  - the enum wstate_e {IDLE, LOAD, FULL};
  - the constant KERNEL_TAPS = 9.
- One sub-module is natural: weight_bank. It is an N-entry register array with write enable, write index, parallel-load input and flattened read.
- weight_bank is instantiated twice: shadow (indexed write) and active (parallel load from shadow).

Test Plan:
- Reset then load 1..9 back-to-back, valid held high, then swap_req. Required: ready stays 1 for 9 cycles, then shadow_full = 1. One cycle after the swap, weight_out taps 0..8 = 1..9 and active_valid = 1.
- With an active set 1..9, load 0x10..0x18 with valid toggling every other cycle. Required: weight_out stays 1..9 throughout the load. After the swap, the taps read 0x10..0x18.
- swap_req after 4 of 9 words. Required: swap_err pulses for 1 cycle, weight_out is unchanged, and state stays LOAD. The remaining 5 words then complete the load to FULL.
- clear after 6 words, then load 9 words of 0xAA and swap. Required: all taps = 0xAA, with no stale words 1..6 in any tap.
- Final word and swap_req in the same cycle. Required: shadow_full = 1, swap_err = 1, weight_out is unchanged. A swap_req on the next cycle then swaps.
- In FULL, hold weight_valid = 1 with weight_in = 0xFF for 5 cycles, then swap. Required: ready = 0 for those cycles and the shadow is unchanged. Separately, asserting reset mid-load zeros weight_out asynchronously.
